// File: rtl/sb_arbiter.sv
// Two-master arbiter between the debug SB master and the core data port onto one memory port.
// Define SB_ARB_RR_EN for round-robin on contention; otherwise debug has fixed priority.
module sb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_read,
  input  logic          dbg_write,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ready,
  output logic          dbg_err,
  output logic          dbg_busy,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_read,
  input  logic          core_write,
  output logic [DW-1:0] core_rdata,
  output logic          core_ready,
  output logic          core_err,
  output logic          core_busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  // state | meaning
  // IDLE  | no transfer on the memory port; grant a pending port if any
  // BUSY  | strobe held on the memory port until mem_ready or timeout
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t state_q, state_d;

  logic [AW-1:0] dbg_addr_q, dbg_addr_d, core_addr_q, core_addr_d;
  logic [DW-1:0] dbg_wdata_q, dbg_wdata_d, core_wdata_q, core_wdata_d;
  logic          dbg_wr_q, dbg_wr_d, core_wr_q, core_wr_d;
  logic          dbg_pend_q, dbg_pend_d, core_pend_q, core_pend_d;
  logic          grant_q, grant_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d, core_rdata_q, core_rdata_d;
  logic          dbg_ready_q, dbg_ready_d, core_ready_q, core_ready_d;
  logic          dbg_err_q, dbg_err_d, core_err_q, core_err_d;
`ifdef SB_ARB_RR_EN
  logic          last_q, last_d;
`endif

  logic dbg_inflight, core_inflight, dbg_cap, core_cap, pick_core, tmo_hit;

  // grant_q: 1 = core owns the memory port
  assign dbg_inflight  = (state_q == S_BUSY) && !grant_q;
  assign core_inflight = (state_q == S_BUSY) &&  grant_q;
  assign dbg_cap       = (dbg_read  | dbg_write)  && !dbg_pend_q  && !dbg_inflight;
  assign core_cap      = (core_read | core_write) && !core_pend_q && !core_inflight;
  assign tmo_hit       = (TIMEOUT != 0) && ((cnt_q + 16'd1) == TMO);

`ifdef SB_ARB_RR_EN
  assign pick_core = core_pend_q && (!dbg_pend_q || !last_q);
`else
  assign pick_core = core_pend_q && !dbg_pend_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (dbg_pend_q || core_pend_q) state_d = S_BUSY;
      S_BUSY: if (mem_ready || tmo_hit)      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dbg_addr_d   = dbg_addr_q;
    dbg_wdata_d  = dbg_wdata_q;
    dbg_wr_d     = dbg_wr_q;
    dbg_pend_d   = dbg_pend_q;
    core_addr_d  = core_addr_q;
    core_wdata_d = core_wdata_q;
    core_wr_d    = core_wr_q;
    core_pend_d  = core_pend_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    dbg_rdata_d  = dbg_rdata_q;
    core_rdata_d = core_rdata_q;
    dbg_ready_d  = 1'b0;
    dbg_err_d    = 1'b0;
    core_ready_d = 1'b0;
    core_err_d   = 1'b0;
`ifdef SB_ARB_RR_EN
    last_d       = last_q;
`endif

    if (dbg_cap) begin
      dbg_addr_d  = dbg_addr;
      dbg_wdata_d = dbg_wdata;
      dbg_wr_d    = dbg_write;
      dbg_pend_d  = 1'b1;
    end
    if (core_cap) begin
      core_addr_d  = core_addr;
      core_wdata_d = core_wdata;
      core_wr_d    = core_write;
      core_pend_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dbg_pend_q || core_pend_q) begin
          grant_d     = pick_core;
          cnt_d       = 16'd0;
          mem_addr_d  = pick_core ? core_addr_q  : dbg_addr_q;
          mem_wdata_d = pick_core ? core_wdata_q : dbg_wdata_q;
          mem_write_d = pick_core ? core_wr_q    : dbg_wr_q;
          mem_read_d  = pick_core ? !core_wr_q   : !dbg_wr_q;
`ifdef SB_ARB_RR_EN
          last_d      = pick_core;
`endif
          if (pick_core) core_pend_d = 1'b0;
          else           dbg_pend_d  = 1'b0;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (grant_q) begin
            core_ready_d = 1'b1;
            if (!mem_write_q) core_rdata_d = mem_rdata;
          end else begin
            dbg_ready_d = 1'b1;
            if (!mem_write_q) dbg_rdata_d = mem_rdata;
          end
        end else if (tmo_hit) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (grant_q) begin
            core_ready_d = 1'b1;
            core_err_d   = 1'b1;
            core_rdata_d = '0;
          end else begin
            dbg_ready_d = 1'b1;
            dbg_err_d   = 1'b1;
            dbg_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
      dbg_wr_q     <= 1'b0;
      dbg_pend_q   <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      core_wr_q    <= 1'b0;
      core_pend_q  <= 1'b0;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      dbg_rdata_q  <= '0;
      core_rdata_q <= '0;
      dbg_ready_q  <= 1'b0;
      dbg_err_q    <= 1'b0;
      core_ready_q <= 1'b0;
      core_err_q   <= 1'b0;
`ifdef SB_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      dbg_addr_q   <= dbg_addr_d;
      dbg_wdata_q  <= dbg_wdata_d;
      dbg_wr_q     <= dbg_wr_d;
      dbg_pend_q   <= dbg_pend_d;
      core_addr_q  <= core_addr_d;
      core_wdata_q <= core_wdata_d;
      core_wr_q    <= core_wr_d;
      core_pend_q  <= core_pend_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      dbg_rdata_q  <= dbg_rdata_d;
      core_rdata_q <= core_rdata_d;
      dbg_ready_q  <= dbg_ready_d;
      dbg_err_q    <= dbg_err_d;
      core_ready_q <= core_ready_d;
      core_err_q   <= core_err_d;
`ifdef SB_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_ready  = dbg_ready_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_busy   = dbg_pend_q | dbg_inflight;
  assign core_rdata = core_rdata_q;
  assign core_ready = core_ready_q;
  assign core_err   = core_err_q;
  assign core_busy  = core_pend_q | core_inflight;

endmodule

// File: tb/tb_sb_arbiter.sv
// Scoreboard bench for sb_arbiter: expected memory transactions and port responses are
// queued at issue time and checked by a negedge monitor. Honours SB_ARB_RR_EN.
module tb_sb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0, core_addr = '0, core_wdata = '0;
  logic        dbg_read = 1'b0, dbg_write = 1'b0, core_read = 1'b0, core_write = 1'b0;
  logic [31:0] dbg_rdata, core_rdata, mem_addr, mem_wdata;
  logic        dbg_ready, dbg_err, dbg_busy, core_ready, core_err, core_busy;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  sb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_read(dbg_read), .dbg_write(dbg_write),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready), .dbg_err(dbg_err), .dbg_busy(dbg_busy),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_read(core_read), .core_write(core_write),
    .core_rdata(core_rdata), .core_ready(core_ready), .core_err(core_err), .core_busy(core_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic wr; int width; } txn_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;

  txn_t exp_txn[$];
  rsp_t exp_dbg[$];
  rsp_t exp_core[$];
  int checks = 0, failures = 0, txn_pushed = 0, txn_seen = 0;
  int mem_wait = 0;          // -1: memory never answers
  logic [31:0] rd_val = '0;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push_txn(logic [31:0] a, logic [31:0] d, logic wr, int w);
    txn_t t;
    t.addr = a; t.wdata = d; t.wr = wr; t.width = w;
    exp_txn.push_back(t);
    txn_pushed++;
  endtask

  task automatic push_rsp(logic core, logic [31:0] rd, logic err);
    rsp_t r;
    r.rdata = rd; r.err = err;
    if (core) exp_core.push_back(r);
    else      exp_dbg.push_back(r);
  endtask

  // memory model: answers after mem_wait extra cycles of strobe
  int busy_cyc = 0;
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      busy_cyc++;
      mem_ready = (mem_wait >= 0) && (busy_cyc > mem_wait);
    end else begin
      busy_cyc  = 0;
      mem_ready = 1'b0;
    end
    mem_rdata = mem_ready ? rd_val : 32'hBAD0BAD0;
  end

  logic prev_strobe = 1'b0;
  logic strobe;
  int   width = 0;
  txn_t cur;
  rsp_t r;

  always @(negedge clk) begin
    strobe = mem_read | mem_write;
    if (strobe && !prev_strobe) begin
      txn_seen++;
      if (exp_txn.size() == 0) begin
        checks++; failures++;
        $display("FAIL txn_unexpected: got addr %h rd %b wr %b, expected no transaction", mem_addr, mem_read, mem_write);
      end else begin
        cur = exp_txn.pop_front();
        check32("txn_addr", mem_addr, cur.addr);
        check1("txn_write", mem_write, cur.wr);
        check1("txn_read", mem_read, !cur.wr);
        if (cur.wr) check32("txn_wdata", mem_wdata, cur.wdata);
      end
      width = 1;
    end else if (strobe) begin
      width++;
      check32("addr_stable", mem_addr, cur.addr);
    end else if (prev_strobe && cur.width >= 0) begin
      check32("strobe_width", width, cur.width);
    end
    prev_strobe = strobe;

    if (dbg_ready) begin
      if (exp_dbg.size() == 0) begin
        checks++; failures++;
        $display("FAIL dbg_rsp_unexpected: got rdata %h err %b, expected none", dbg_rdata, dbg_err);
      end else begin
        r = exp_dbg.pop_front();
        check32("dbg_rdata", dbg_rdata, r.rdata);
        check1("dbg_err", dbg_err, r.err);
        check1("dbg_busy_at_ready", dbg_busy, 1'b0);
      end
    end
    if (core_ready) begin
      if (exp_core.size() == 0) begin
        checks++; failures++;
        $display("FAIL core_rsp_unexpected: got rdata %h err %b, expected none", core_rdata, core_err);
      end else begin
        r = exp_core.pop_front();
        check32("core_rdata", core_rdata, r.rdata);
        check1("core_err", core_err, r.err);
        check1("core_busy_at_ready", core_busy, 1'b0);
      end
    end
  end

  task automatic pulse();
    @(posedge clk);
    #2;
    dbg_read = 1'b0; dbg_write = 1'b0; core_read = 1'b0; core_write = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    @(negedge clk);
    while ((dbg_busy || core_busy || mem_read || mem_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL %s_idle_timeout: got still busy after %0d cycles, expected idle", name, n);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check1("rst_mem_read", mem_read, 1'b0);
    check1("rst_mem_write", mem_write, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_rdata", dbg_rdata | core_rdata, 32'h0);
    check1("rst_ready_err_busy", dbg_ready | dbg_err | dbg_busy | core_ready | core_err | core_busy, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // debug read, zero wait, latency check
    mem_wait = 0; rd_val = 32'hDEADBEEF;
    push_txn(32'h40, 32'h0, 1'b0, 1);
    push_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    dbg_addr = 32'h40; dbg_read = 1'b1;
    @(posedge clk);
    #2 dbg_read = 1'b0;
    check1("t1_pending_busy", dbg_busy, 1'b1);
    check1("t1_no_strobe_yet", mem_read, 1'b0);
    @(posedge clk);
    #1 check1("t1_grant_strobe", mem_read, 1'b1);
    @(posedge clk);
    #1 check1("t1_ready_at_e3", dbg_ready, 1'b1);
    check1("t1_strobe_dropped", mem_read, 1'b0);
    wait_idle("t1");

    // core read with two wait cycles
    mem_wait = 2; rd_val = 32'h55AA55AA;
    push_txn(32'h80, 32'h0, 1'b0, 3);
    push_rsp(1'b1, 32'h55AA55AA, 1'b0);
    core_addr = 32'h80; core_read = 1'b1;
    pulse();
    wait_idle("t2");

    // core read timeout
    mem_wait = -1;
    push_txn(32'h84, 32'h0, 1'b0, 4);
    push_rsp(1'b1, 32'h0, 1'b1);
    core_addr = 32'h84; core_read = 1'b1;
    pulse();
    wait_idle("t3");

    // contention straight after reset: debug first in both modes
    mem_wait = 0;
    push_txn(32'h100, 32'hA1, 1'b1, 1);
    push_txn(32'h200, 32'hB2, 1'b1, 1);
    push_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    push_rsp(1'b1, 32'h0, 1'b0);
    dbg_addr = 32'h100; dbg_wdata = 32'hA1; dbg_write = 1'b1;
    core_addr = 32'h200; core_wdata = 32'hB2; core_write = 1'b1;
    pulse();
    wait_idle("t4");

    // lone debug write leaves debug as last granted
    push_txn(32'h104, 32'hC3, 1'b1, 1);
    push_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    dbg_addr = 32'h104; dbg_wdata = 32'hC3; dbg_write = 1'b1;
    pulse();
    wait_idle("t5");

    // contention again: round-robin favours core, fixed priority favours debug
`ifdef SB_ARB_RR_EN
    push_txn(32'h208, 32'hE5, 1'b1, 1);
    push_txn(32'h108, 32'hD4, 1'b1, 1);
`else
    push_txn(32'h108, 32'hD4, 1'b1, 1);
    push_txn(32'h208, 32'hE5, 1'b1, 1);
`endif
    push_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    push_rsp(1'b1, 32'h0, 1'b0);
    dbg_addr = 32'h108; dbg_wdata = 32'hD4; dbg_write = 1'b1;
    core_addr = 32'h208; core_wdata = 32'hE5; core_write = 1'b1;
    pulse();
    wait_idle("t6");

    // second debug pulse while in flight is dropped
    mem_wait = 2; rd_val = 32'h11112222;
    push_txn(32'h48, 32'h0, 1'b0, 3);
    push_rsp(1'b0, 32'h11112222, 1'b0);
    dbg_addr = 32'h48; dbg_read = 1'b1;
    pulse();
    @(posedge clk);
    #2 dbg_addr = 32'h4C; dbg_read = 1'b1;
    pulse();
    wait_idle("t7");
    repeat (3) @(posedge clk);
    #2;

    // read and write together become a write
    mem_wait = 0;
    push_txn(32'h4C, 32'h1234, 1'b1, 1);
    push_rsp(1'b0, 32'h11112222, 1'b0);
    dbg_addr = 32'h4C; dbg_wdata = 32'h1234; dbg_read = 1'b1; dbg_write = 1'b1;
    pulse();
    wait_idle("t8");

    // async reset in the middle of a write
    mem_wait = -1;
    push_txn(32'h60, 32'h77, 1'b1, -1);
    dbg_addr = 32'h60; dbg_wdata = 32'h77; dbg_write = 1'b1;
    pulse();
    @(posedge clk);
    #1 check1("t9_write_high", mem_write, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("t9_rst_write_low", mem_write, 1'b0);
    check1("t9_rst_busy_low", dbg_busy | core_busy, 1'b0);
    check32("t9_rst_rdata", dbg_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check1("t9_no_stale_strobe", mem_read | mem_write, 1'b0);
    check1("t9_no_stale_busy", dbg_busy | core_busy, 1'b0);
    @(posedge clk);
    #2;

    // normal traffic after reset
    mem_wait = 0; rd_val = 32'hCAFEF00D;
    push_txn(32'h70, 32'h0, 1'b0, 1);
    push_rsp(1'b0, 32'hCAFEF00D, 1'b0);
    dbg_addr = 32'h70; dbg_read = 1'b1;
    pulse();
    wait_idle("t10");

    repeat (4) @(posedge clk);
    #1;
    check32("txn_count", txn_seen, txn_pushed);
    check32("txn_queue_left", exp_txn.size(), 0);
    check32("dbg_rsp_left", exp_dbg.size(), 0);
    check32("core_rsp_left", exp_core.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
